// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encodings, default timing constants and counter-width helper for key_debounce
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // 20 ms debounce and 1 s long-press at a 50 MHz sys_clk
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_LONG_CYCLES     = 50_000_000;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-flop synchronizer, debounce FSM, counter, registered event outputs
// Long-press counting is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
`ifdef KEY_LONG_PRESS_EN
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
`endif
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

`ifdef KEY_LONG_PRESS_EN
    localparam int CNT_W = cnt_width(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`else
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
`endif
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic RELEASED_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
`ifdef KEY_LONG_PRESS_EN
    logic             long_q, long_d;
`endif

    // s is 1 whenever the synchronized pin differs from its released level
    assign s = sync_q[1] ^ RELEASED_RAW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef KEY_LONG_PRESS_EN
                else begin
                    // saturating at LONG_MAX keeps the LONG_LAST match to one cycle per press
                    if (cnt_q != LONG_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    long_d = (cnt_q == LONG_LAST);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q    <= {2{RELEASED_RAW}};
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            long_q <= 1'b0;
        end else begin
            long_q <= long_d;
        end
    end
    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel push-button conditioner with debounced levels and press/release/long events
// Define KEY_LONG_PRESS_EN to enable long-press detection on key_long.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("key_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef KEY_LONG_PRESS_EN
            .LONG_CYCLES    (LONG_CYCLES),
`endif
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .key_in     (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule
